// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU: register file, valid/ready instruction intake,
// carry/zero flags, multi-cycle shift-add MUL and strobed OUT. Option: ACC_CPU_SAT_EN.
module acc_cpu_param #(
  parameter  int DATA_W  = 8,
  parameter  int NREG    = 4,
  localparam int RIDX_W  = $clog2(NREG),
  localparam int INSTR_W = 4 + RIDX_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  acc_out,
  output logic               flag_z,
  output logic               flag_c,
  output logic               busy,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR   = 4'h4, OP_NOT = 4'h5, OP_LDI = 4'h6, OP_ST  = 4'h7,
    OP_LD   = 4'h8, OP_ADDR = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
    OP_MUL  = 4'hC, OP_OUT = 4'hD, OP_NOPE = 4'hE, OP_NOPF = 4'hF
  } opcode_t;

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t                state;
  logic [DATA_W-1:0]     acc;
  logic [DATA_W-1:0]     regs [NREG];
  logic [2*DATA_W-1:0]   prod;
  logic [2*DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]     mplier;
  logic [CNT_W-1:0]      cnt;

  opcode_t               op;
  logic [RIDX_W-1:0]     rd;
  logic [DATA_W-1:0]     imm;
  logic [DATA_W:0]       sum;
  logic [DATA_W:0]       diff;
  logic [DATA_W:0]       sum_r;
  logic                  wr_acc;
  logic [DATA_W-1:0]     nxt_acc;
  logic                  nxt_c;
  logic [2*DATA_W-1:0]   step_prod;
  logic                  mul_hi_nz;
  logic [DATA_W-1:0]     mul_res;

  assign op          = opcode_t'(instr[3:0]);
  assign rd          = instr[4 +: RIDX_W];
  assign imm         = instr[INSTR_W-1 -: DATA_W];
  assign instr_ready = (state == IDLE);
  assign acc_out     = acc;

  // Single-cycle datapath; the MSB of each extended sum is the raw carry/borrow.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, imm};
    diff    = {1'b0, acc} - {1'b0, imm};
    sum_r   = {1'b0, acc} + {1'b0, regs[rd]};
    wr_acc  = 1'b1;
    nxt_acc = acc;
    nxt_c   = flag_c;
    case (op)
`ifdef ACC_CPU_SAT_EN
      OP_ADD:  begin nxt_acc = sum[DATA_W]   ? '1 : sum[DATA_W-1:0];   nxt_c = sum[DATA_W];   end
      OP_SUB:  begin nxt_acc = diff[DATA_W]  ? '0 : diff[DATA_W-1:0];  nxt_c = diff[DATA_W];  end
      OP_ADDR: begin nxt_acc = sum_r[DATA_W] ? '1 : sum_r[DATA_W-1:0]; nxt_c = sum_r[DATA_W]; end
`else
      OP_ADD:  begin nxt_acc = sum[DATA_W-1:0];   nxt_c = sum[DATA_W];   end
      OP_SUB:  begin nxt_acc = diff[DATA_W-1:0];  nxt_c = diff[DATA_W];  end
      OP_ADDR: begin nxt_acc = sum_r[DATA_W-1:0]; nxt_c = sum_r[DATA_W]; end
`endif
      OP_AND:  nxt_acc = acc & imm;
      OP_OR:   nxt_acc = acc | imm;
      OP_NOT:  nxt_acc = ~acc;
      OP_LDI:  nxt_acc = imm;
      OP_LD:   nxt_acc = regs[rd];
      OP_SHL:  begin nxt_acc = {acc[DATA_W-2:0], 1'b0}; nxt_c = acc[DATA_W-1]; end
      OP_SHR:  begin nxt_acc = {1'b0, acc[DATA_W-1:1]}; nxt_c = acc[0];        end
      default: wr_acc = 1'b0;
    endcase
  end

  // One shift-add step; the multiplicand walks left as the multiplier walks right.
  always_comb begin
    step_prod = prod + (mplier[0] ? mcand : '0);
    mul_hi_nz = |step_prod[2*DATA_W-1:DATA_W];
`ifdef ACC_CPU_SAT_EN
    mul_res   = mul_hi_nz ? '1 : step_prod[DATA_W-1:0];
`else
    mul_res   = step_prod[DATA_W-1:0];
`endif
  end

  // NOTE: the register file is reset explicitly because the reset state of every
  // register is architecturally visible through LD/ADDR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            case (op)
              OP_MUL: begin
                mcand  <= {{DATA_W{1'b0}}, acc};
                mplier <= imm;
                prod   <= '0;
                cnt    <= CNT_W'(DATA_W);
                state  <= MUL;
                busy   <= 1'b1;
              end
              OP_OUT: begin
                out_data  <= acc;
                out_valid <= 1'b1;
              end
              OP_ST: regs[rd] <= acc;
              default: begin
                if (wr_acc) begin
                  acc    <= nxt_acc;
                  flag_z <= (nxt_acc == '0);
                end
                flag_c <= nxt_c;
              end
            endcase
          end
        end
        MUL: begin
          prod   <= step_prod;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            acc    <= mul_res;
            flag_c <= mul_hi_nz;
            flag_z <= (mul_res == '0);
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed bench for acc_cpu_param at DATA_W=8, NREG=4; expected values are hand-derived.
module tb_acc_cpu_param;

  localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, SUB = 4'h2, AND_ = 4'h3, OR_ = 4'h4,
                         NOT_ = 4'h5, LDI = 4'h6, ST = 4'h7, LD = 4'h8, ADDR = 4'h9,
                         SHL = 4'hA, SHR = 4'hB, MULO = 4'hC, OUTO = 4'hD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  acc_out;
  logic        flag_z, flag_c, busy;
  logic [7:0]  out_data;
  logic        out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  acc_cpu_param #(.DATA_W(8), .NREG(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .acc_out(acc_out), .flag_z(flag_z), .flag_c(flag_c),
    .busy(busy), .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Present one instruction for one edge; rdy reports instr_ready seen just before that edge.
  task automatic step(input logic [3:0] op, input logic [1:0] rd, input logic [7:0] imm,
                      output logic rdy);
    instr       = {imm, rd, op};
    instr_valid = 1'b1;
    rdy         = instr_ready;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic r;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(LDI, 0, 8'h5A, r);
    step(ADD, 0, 8'hFF, r);
    step(OUTO, 0, 8'h00, r);
    // Reset mid-stream with an instruction offered: the accept must be ignored.
    rst_n = 1'b0;
    step(LDI, 0, 8'h33, r);
    step(LDI, 0, 8'h33, r);
    rst_n = 1'b1; instr_valid = 1'b0;
    n_cmp++; if (acc_out !== 8'h00) begin n_bad++; $display("FAIL reset_acc: got %h want 00", acc_out); end
    n_cmp++; if ({flag_z, flag_c} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got zc=%b want 00", {flag_z, flag_c}); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_cmp++; if ({out_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL reset_strobe_busy: got %b want 00", {out_valid, busy}); end
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    // Register file must be cleared too.
    step(LD, 2, 8'h00, r);
    n_cmp++; if ({acc_out, flag_z} !== {8'h00, 1'b1}) begin n_bad++; $display("FAIL reset_regs: got acc=%h z=%b want 00 z=1", acc_out, flag_z); end
  endtask

  task automatic test_back_to_back();
    logic r0, r1, r2, r3;
    step(LDI, 0, 8'h05, r0);
    step(ADD, 0, 8'h03, r1);
    n_cmp++; if ({acc_out, flag_z, flag_c} !== {8'h08, 2'b00}) begin n_bad++; $display("FAIL b2b_add: got acc=%h z=%b c=%b want 08 0 0", acc_out, flag_z, flag_c); end
    step(OUTO, 0, 8'h00, r2);
    n_cmp++; if ({out_valid, out_data} !== {1'b1, 8'h08}) begin n_bad++; $display("FAIL b2b_out: got v=%b d=%h want 1 08", out_valid, out_data); end
    idle();
    n_cmp++; if ({out_valid, out_data} !== {1'b0, 8'h08}) begin n_bad++; $display("FAIL b2b_out_hold: got v=%b d=%h want 0 08", out_valid, out_data); end
    r3 = instr_ready;
    n_cmp++; if ({r0, r1, r2, r3} !== 4'b1111) begin n_bad++; $display("FAIL b2b_ready: got %b want 1111", {r0, r1, r2, r3}); end
  endtask

  task automatic test_flags();
    logic r;
    step(LDI, 0, 8'h00, r);
    step(SUB, 0, 8'h01, r);
`ifdef ACC_CPU_SAT_EN
    n_cmp++; if ({acc_out, flag_z, flag_c} !== {8'h00, 2'b11}) begin n_bad++; $display("FAIL sub_borrow: got acc=%h z=%b c=%b want 00 1 1", acc_out, flag_z, flag_c); end
    step(ADD, 0, 8'h01, r);
    n_cmp++; if ({acc_out, flag_z, flag_c} !== {8'h01, 2'b00}) begin n_bad++; $display("FAIL add_carry: got acc=%h z=%b c=%b want 01 0 0", acc_out, flag_z, flag_c); end
`else
    n_cmp++; if ({acc_out, flag_z, flag_c} !== {8'hFF, 2'b01}) begin n_bad++; $display("FAIL sub_borrow: got acc=%h z=%b c=%b want ff 0 1", acc_out, flag_z, flag_c); end
    step(ADD, 0, 8'h01, r);
    n_cmp++; if ({acc_out, flag_z, flag_c} !== {8'h00, 2'b11}) begin n_bad++; $display("FAIL add_carry: got acc=%h z=%b c=%b want 00 1 1", acc_out, flag_z, flag_c); end
`endif
  endtask

  task automatic test_mul();
    logic r;
    int   n;
    logic held;
    step(LDI, 0, 8'h0F, r);
    step(MULO, 0, 8'd17, r);
    instr_valid = 1'b0;
    n = 0; held = 1'b1;
    while (instr_ready !== 1'b1 && n < 40) begin
      if (busy !== 1'b1 || acc_out !== 8'h0F) held = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL mul_ready_low: got %0d cycles want 8", n); end
    n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL mul_busy_hold: got %b want 1", held); end
    n_cmp++; if ({acc_out, flag_z, flag_c, busy} !== {8'hFF, 3'b000}) begin n_bad++; $display("FAIL mul_15x17: got acc=%h z=%b c=%b busy=%b want ff 0 0 0", acc_out, flag_z, flag_c, busy); end
    step(MULO, 0, 8'd2, r);
    instr_valid = 1'b0;
    n = 0;
    while (instr_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
`ifdef ACC_CPU_SAT_EN
    n_cmp++; if ({acc_out, flag_c} !== {8'hFF, 1'b1}) begin n_bad++; $display("FAIL mul_x2: got acc=%h c=%b want ff 1", acc_out, flag_c); end
`else
    n_cmp++; if ({acc_out, flag_c} !== {8'hFE, 1'b1}) begin n_bad++; $display("FAIL mul_x2: got acc=%h c=%b want fe 1", acc_out, flag_c); end
`endif
  endtask

  task automatic test_regs_shift();
    logic r;
    step(LDI, 0, 8'h3C, r);
    step(ST, 2, 8'h00, r);
    step(LDI, 0, 8'h00, r);
    step(ADDR, 2, 8'h00, r);
    n_cmp++; if ({acc_out, flag_c} !== {8'h3C, 1'b0}) begin n_bad++; $display("FAIL addr_r2: got acc=%h c=%b want 3c 0", acc_out, flag_c); end
    step(SHL, 0, 8'h00, r);
    n_cmp++; if ({acc_out, flag_c} !== {8'h78, 1'b0}) begin n_bad++; $display("FAIL shl_1: got acc=%h c=%b want 78 0", acc_out, flag_c); end
    step(SHL, 0, 8'h00, r);
    step(SHL, 0, 8'h00, r);
    n_cmp++; if ({acc_out, flag_c} !== {8'hE0, 1'b1}) begin n_bad++; $display("FAIL shl_3: got acc=%h c=%b want e0 1", acc_out, flag_c); end
    step(LD, 2, 8'h00, r);
    step(SHR, 0, 8'h00, r);
    n_cmp++; if ({acc_out, flag_c} !== {8'h1E, 1'b0}) begin n_bad++; $display("FAIL shr: got acc=%h c=%b want 1e 0", acc_out, flag_c); end
    step(NOT_, 0, 8'h00, r);
    step(AND_, 0, 8'h0F, r);
    n_cmp++; if (acc_out !== 8'h01) begin n_bad++; $display("FAIL not_and: got acc=%h want 01", acc_out); end
    step(SHR, 0, 8'h00, r);
    n_cmp++; if ({acc_out, flag_z, flag_c} !== {8'h00, 2'b11}) begin n_bad++; $display("FAIL shr_zero: got acc=%h z=%b c=%b want 00 1 1", acc_out, flag_z, flag_c); end
    step(OR_, 0, 8'h80, r);
    step(4'hE, 0, 8'h55, r);
    n_cmp++; if ({acc_out, flag_z, flag_c} !== {8'h80, 2'b01}) begin n_bad++; $display("FAIL or_nop_hold: got acc=%h z=%b c=%b want 80 0 1", acc_out, flag_z, flag_c); end
  endtask

  task automatic test_mul_abort();
    logic r;
    step(LDI, 0, 8'h07, r);
    step(MULO, 0, 8'h03, r);
    idle();
    idle();
    n_cmp++; if ({busy, acc_out} !== {1'b1, 8'h07}) begin n_bad++; $display("FAIL abort_pre: got busy=%b acc=%h want 1 07", busy, acc_out); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++; if ({acc_out, busy, instr_ready} !== {8'h00, 2'b01}) begin n_bad++; $display("FAIL abort_reset: got acc=%h busy=%b rdy=%b want 00 0 1", acc_out, busy, instr_ready); end
    repeat (10) idle();
    n_cmp++; if (acc_out !== 8'h00) begin n_bad++; $display("FAIL abort_no_write: got acc=%h want 00", acc_out); end
    step(LDI, 0, 8'h09, r);
    n_cmp++; if ({r, acc_out} !== {1'b1, 8'h09}) begin n_bad++; $display("FAIL abort_ldi: got rdy=%b acc=%h want 1 09", r, acc_out); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_flags();
    test_mul();
    test_regs_shift();
    test_mul_abort();
    instr_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
